alu_sequencer: RTL and testbench

Multi-cycle controller that sequences the shared 16-bit ALU for register-register instructions. Per accepted request it:
- reads two register-file operands,
- routes them onto the ALU A/B inputs in the order each opcode requires,
- captures the result and flags,
- writes back to Rdest and updates the processor status flag register.

It sits between instruction decode and the register file/ALU pair.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_operand_mux.sv | 47 ++++
 rtl/alu_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state definitions for the ALU sequencer.
// Opcode values must stay identical to the ALU's own decode.
package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_NOT  = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} seq_state_e;

  function automatic logic is_legal_op(input logic [7:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_NOT,
      OP_SUB, OP_CMP, OP_MOV, OP_LSH, OP_ASHU: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Only the arithmetic/compare group owns the architectural flags.
  function automatic logic updates_psr(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

  function automatic logic imm_sign_ext(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) ||
           (op == OP_LSH) || (op == OP_ASHU) || (op == OP_MOV);
  endfunction

endpackage

// File: rtl/alu_operand_mux.sv
// Routes Rdest/Rsrc values onto ALU A/B per opcode.
// With ALU_SEQ_IMM_EN defined, an 8-bit immediate can stand in for Rsrc.
module alu_operand_mux
  import alu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [7:0]        op,
  input  logic [DATA_W-1:0] rdest_val,
  input  logic [DATA_W-1:0] rsrc_val,
`ifdef ALU_SEQ_IMM_EN
  input  logic              imm_sel,
  input  logic [7:0]        imm,
`endif
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b
);

  logic [DATA_W-1:0] src;

`ifdef ALU_SEQ_IMM_EN
  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = imm_sign_ext(op) ? {{(DATA_W-8){imm[7]}}, imm}
                                    : {{(DATA_W-8){1'b0}}, imm};
  assign src = imm_sel ? imm_ext : rsrc_val;
`else
  assign src = rsrc_val;
`endif

  // CMP swaps operands so L/N read as Rdest < Rsrc.
  always_comb begin
    a = rdest_val;
    b = src;
    case (op)
      OP_CMP: begin
        a = src;
        b = rdest_val;
      end
      OP_MOV, OP_NOT: begin
        a = src;
        b = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Four-state controller sequencing RF read, shared ALU execute and writeback.
// Optional immediate operand enabled by defining ALU_SEQ_IMM_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int DATA_W     = 16,
  parameter int FLAG_W     = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [7:0]            req_op,
  input  logic [REG_ADDR_W-1:0] req_rdest,
  input  logic [REG_ADDR_W-1:0] req_rsrc,
`ifdef ALU_SEQ_IMM_EN
  input  logic                  req_imm_sel,
  input  logic [7:0]            req_imm,
`endif
  output logic [REG_ADDR_W-1:0] rf_raddr_a,
  output logic [REG_ADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0]     rf_rdata_a,
  input  logic [DATA_W-1:0]     rf_rdata_b,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [7:0]            alu_op,
  input  logic [DATA_W-1:0]     alu_out,
  input  logic [FLAG_W-1:0]     alu_flags,
  output logic [FLAG_W-1:0]     psr_flags,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  if (DATA_W != 16) begin : g_width_chk
    $error("alu_sequencer: DATA_W must be 16");
  end

  seq_state_e        state, state_nx;
  logic [7:0]        op_q;
  logic [DATA_W-1:0] result;
  logic [FLAG_W-1:0] flag_cap;
  logic [DATA_W-1:0] mux_a, mux_b;

`ifdef ALU_SEQ_IMM_EN
  logic       imm_sel_q;
  logic [7:0] imm_q;
`endif

  alu_operand_mux #(.DATA_W(DATA_W)) u_mux (
    .op        (op_q),
    .rdest_val (rf_rdata_a),
    .rsrc_val  (rf_rdata_b),
`ifdef ALU_SEQ_IMM_EN
    .imm_sel   (imm_sel_q),
    .imm       (imm_q),
`endif
    .a         (mux_a),
    .b         (mux_b)
  );

  // The read-address registers double as the latched Rdest/Rsrc fields.
  assign rf_waddr = rf_raddr_a;
  assign rf_wdata = result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      result     <= '0;
      flag_cap   <= '0;
      psr_flags  <= '0;
`ifdef ALU_SEQ_IMM_EN
      imm_sel_q  <= 1'b0;
      imm_q      <= '0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (req_valid) begin
          op_q       <= req_op;
          rf_raddr_a <= req_rdest;
          rf_raddr_b <= req_rsrc;
`ifdef ALU_SEQ_IMM_EN
          imm_sel_q  <= req_imm_sel;
          imm_q      <= req_imm;
`endif
        end
        S_READ: begin
          alu_a <= mux_a;
          alu_b <= mux_b;
        end
        S_EXEC: begin
          result   <= alu_out;
          flag_cap <= alu_flags;
        end
        S_WB: if (is_legal_op(op_q) && updates_psr(op_q)) psr_flags <= flag_cap;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    rf_we     = 1'b0;
    alu_op    = 8'h00;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = S_READ;
      end
      S_READ: state_nx = S_EXEC;
      S_EXEC: begin
        alu_op   = op_q;
        state_nx = S_WB;
      end
      S_WB: begin
        done     = 1'b1;
        err      = !is_legal_op(op_q);
        rf_we    = is_legal_op(op_q) && (op_q != OP_CMP);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and ALU.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_op = 8'h00;
  logic [3:0]  req_rdest = 4'h0;
  logic [3:0]  req_rsrc = 4'h0;
`ifdef ALU_SEQ_IMM_EN
  logic        req_imm_sel = 1'b0;
  logic [7:0]  req_imm = 8'h00;
`endif
  logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic        rf_we;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [7:0]  alu_op;
  logic [4:0]  alu_flags, psr_flags;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [15:0] regs [16];
  logic        pl_we = 1'b0;
  logic [3:0]  pl_addr = 4'h0;
  logic [15:0] pl_data = 16'h0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rdest(req_rdest), .req_rsrc(req_rsrc),
`ifdef ALU_SEQ_IMM_EN
    .req_imm_sel(req_imm_sel), .req_imm(req_imm),
`endif
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
    .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .psr_flags(psr_flags), .busy(busy), .done(done), .err(err)
  );

  always @(posedge clk) begin
    if (rf_we) regs[rf_waddr] <= rf_wdata;
    else if (pl_we) regs[pl_addr] <= pl_data;
  end
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  // Flags {N,Z,F,L,C}; unknown opcodes return a loud pattern.
  function automatic logic [20:0] alu_model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    r = 16'hDEAD;
    f = 5'h1F;
    case (op)
      8'h05: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0];
        f = {r[15], r == 16'h0, (a[15] == b[15]) && (r[15] != a[15]), 1'b0, s[16]};
      end
      8'h09: begin
        s = {1'b0, a} - {1'b0, b}; r = s[15:0];
        f = {r[15], r == 16'h0, (a[15] != b[15]) && (r[15] != a[15]), 1'b0, s[16]};
      end
      8'h0B: begin
        r = a - b;
        f = {$signed(b) < $signed(a), a == b, 1'b0, b < a, 1'b0};
      end
      8'h02: begin r = a | b; f = {1'b0, r == 16'h0, 3'b000}; end
      8'h01: begin r = a & b; f = 5'h0; end
      8'h03: begin r = a ^ b; f = 5'h0; end
      8'h0D: begin r = a;     f = 5'h0; end
      8'h07: begin r = ~a;    f = 5'h0; end
      default: ;
    endcase
    return {f, r};
  endfunction

  assign {alu_flags, alu_out} = alu_model(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] addr, input logic [15:0] data);
    pl_we = 1'b1; pl_addr = addr; pl_data = data;
    tick();
    pl_we = 1'b0;
  endtask

  // Starts 1 time unit after an edge with the DUT idle; ends the same way.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                        input logic [15:0] ea, input logic [15:0] eb, input logic exp_we,
                        input logic [15:0] exp_wd, input logic exp_err, input logic [4:0] exp_psr,
                        input logic hold);
    req_valid = 1'b1; req_op = op; req_rdest = rd; req_rsrc = rs;
    chk({tag, ".ready"}, req_ready, 1'b1);
    tick();
    if (!hold) req_valid = 1'b0;
    chk({tag, ".read_busy"}, {busy, req_ready, done}, 3'b100);
    chk({tag, ".raddr"}, {rf_raddr_a, rf_raddr_b}, {rd, rs});
    tick();
    chk({tag, ".exec_ctl"}, {req_ready, done, rf_we, alu_op}, {3'b000, op});
    if (!exp_err) chk({tag, ".alu_ab"}, {alu_a, alu_b}, {ea, eb});
    tick();
    chk({tag, ".wb_ctl"}, {req_ready, done, err, rf_we}, {2'b01, exp_err, exp_we});
    if (exp_we) chk({tag, ".wb_data"}, {rf_waddr, rf_wdata}, {rd, exp_wd});
    tick();
    req_valid = 1'b0;
    chk({tag, ".idle"}, {busy, done, rf_we, alu_op}, 11'h0);
    chk({tag, ".psr"}, psr_flags, exp_psr);
    if (exp_we) chk({tag, ".reg"}, regs[rd], exp_wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    tick();
    tick();
    chk("reset.ctl", {req_ready, busy, done, err, rf_we, alu_op}, {5'b10000, 8'h00});
    chk("reset.psr", psr_flags, 5'h0);
    chk("reset.addr", {rf_raddr_a, rf_raddr_b, rf_waddr}, 12'h0);
    chk("reset.data", {alu_a, alu_b, rf_wdata}, 48'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    preload(4'd1, 16'h0003); preload(4'd2, 16'h0004);
    preload(4'd3, 16'h0005); preload(4'd4, 16'h0005);
    preload(4'd5, 16'h0001); preload(4'd6, 16'hFFFF);
    preload(4'd7, 16'h7FFF); preload(4'd8, 16'h0001);
    preload(4'd12, 16'hBEEF); preload(4'd13, 16'h1111);
    preload(4'd14, 16'h0100); preload(4'd15, 16'h0001);

    run_op("add",  8'h05, 4'd1, 4'd2, 16'h0003, 16'h0004, 1'b1, 16'h0007, 1'b0, 5'b00000, 1'b0);
    run_op("sub",  8'h09, 4'd3, 4'd4, 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 5'b01000, 1'b0);
    run_op("cmp",  8'h0B, 4'd5, 4'd6, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 5'b00010, 1'b0);
    chk("cmp.no_write", regs[5], 16'h0001);
    run_op("add2", 8'h05, 4'd7, 4'd8, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 5'b10100, 1'b0);
    run_op("or0",  8'h02, 4'd9, 4'd10, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 5'b10100, 1'b0);
    run_op("mov",  8'h0D, 4'd11, 4'd12, 16'hBEEF, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 5'b10100, 1'b0);
    run_op("ill",  8'hFF, 4'd1, 4'd2, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 5'b10100, 1'b1);
    chk("ill.no_write", regs[1], 16'h0007);
    tick();
    chk("hold.no_reaccept", {busy, req_ready}, 2'b01);

    // Abort an ADD in EXEC; reset must kill writeback and clear the PSR at once.
    req_valid = 1'b1; req_op = 8'h05; req_rdest = 4'd14; req_rsrc = 4'd15;
    tick();
    req_valid = 1'b0;
    tick();
    chk("abort.in_exec", alu_op, 8'h05);
    reset = 1'b1;
    #1;
    chk("abort.async", {busy, rf_we, done, alu_op}, 11'h0);
    chk("abort.psr", psr_flags, 5'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    chk("abort.reg", regs[14], 16'h0100);
    chk("abort.idle", {busy, req_ready}, 2'b01);

    run_op("same", 8'h05, 4'd13, 4'd13, 16'h1111, 16'h1111, 1'b1, 16'h2222, 1'b0, 5'b00000, 1'b0);
    run_op("xor",  8'h03, 4'd14, 4'd15, 16'h0100, 16'h0001, 1'b1, 16'h0101, 1'b0, 5'b00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
